// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: sequences one shared combinational ALU between two requesters.
// Each operation takes one request handshake (IDLE), one cycle for the ALU to
// evaluate the registered operands (EXEC), and a held response until it is
// consumed (RESP). Ties between the requesters are broken round-robin.
// Optional build macro: ALU_SHARE_FIXED_PRIO_EN selects fixed priority, with
// requester 0 winning every tie, and removes the round-robin pointer.
module alu_share_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    // Requester 0
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [OPW-1:0]   req0_op_i,

    // Requester 1
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [OPW-1:0]   req1_op_i,

    // Response 0
    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic [WIDTH-1:0] rsp0_y_o,
    output logic             rsp0_zero_o,

    // Response 1
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp1_y_o,
    output logic             rsp1_zero_o,

    // Shared ALU
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [OPW-1:0]   alu_op_o,
    input  logic [WIDTH-1:0] alu_y_i,
    input  logic             alu_zero_i,

    output logic             busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Operand registers feeding the ALU; they hold after EXEC until the next grant.
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;

    // Owner of the operation in flight: 0 or 1.
    logic             owner_q, owner_d;

    // Per-requester result registers; the non-owner's copy is left untouched.
    logic [WIDTH-1:0] rsp0_y_q, rsp0_y_d;
    logic [WIDTH-1:0] rsp1_y_q, rsp1_y_d;
    logic             rsp0_zero_q, rsp0_zero_d;
    logic             rsp1_zero_q, rsp1_zero_d;

`ifndef ALU_SHARE_FIXED_PRIO_EN
    // Last granted requester; resets to 1 so requester 0 wins the first tie.
    logic             ptr_q, ptr_d;
`endif

    logic gnt0, gnt1;
    logic accept;
    logic rsp_done;

    // Arbitration among valid requesters; only acted upon in IDLE.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        if (req0_valid_i) begin
            gnt0 = 1'b1;
        end else if (req1_valid_i) begin
            gnt1 = 1'b1;
        end
`else
        if (req0_valid_i && req1_valid_i) begin
            // The side that did not win last time goes next.
            gnt0 = ptr_q;
            gnt1 = ~ptr_q;
        end else begin
            gnt0 = req0_valid_i;
            gnt1 = req1_valid_i;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: ready only in IDLE (and never while reset is held),
    // response valid only for the owner while in RESP.
    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        busy_o       = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy_o       = 1'b0;
                req0_ready_o = gnt0 & rst_n;
                req1_ready_o = gnt1 & rst_n;
            end
            StExec: begin
                busy_o = 1'b1;
            end
            StResp: begin
                rsp0_valid_o = ~owner_q;
                rsp1_valid_o = owner_q;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    assign accept   = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
    assign rsp_done = (rsp0_valid_o & rsp0_ready_i) | (rsp1_valid_o & rsp1_ready_i);

    // Datapath next-state: latch the winner's request, then capture the ALU result.
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        owner_d     = owner_q;
        rsp0_y_d    = rsp0_y_q;
        rsp1_y_d    = rsp1_y_q;
        rsp0_zero_d = rsp0_zero_q;
        rsp1_zero_d = rsp1_zero_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif

        if (accept) begin
            owner_d = req1_ready_o;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            ptr_d   = req1_ready_o;
`endif
            if (req1_ready_o) begin
                alu_a_d  = req1_a_i;
                alu_b_d  = req1_b_i;
                alu_op_d = req1_op_i;
            end else begin
                alu_a_d  = req0_a_i;
                alu_b_d  = req0_b_i;
                alu_op_d = req0_op_i;
            end
        end

        if (state_q == StExec) begin
            if (owner_q) begin
                rsp1_y_d    = alu_y_i;
                rsp1_zero_d = alu_zero_i;
            end else begin
                rsp0_y_d    = alu_y_i;
                rsp0_zero_d = alu_zero_i;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            owner_q     <= 1'b0;
            rsp0_y_q    <= '0;
            rsp1_y_q    <= '0;
            rsp0_zero_q <= 1'b0;
            rsp1_zero_q <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            owner_q     <= owner_d;
            rsp0_y_q    <= rsp0_y_d;
            rsp1_y_q    <= rsp1_y_d;
            rsp0_zero_q <= rsp0_zero_d;
            rsp1_zero_q <= rsp1_zero_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign rsp0_y_o    = rsp0_y_q;
    assign rsp1_y_o    = rsp1_y_q;
    assign rsp0_zero_o = rsp0_zero_q;
    assign rsp1_zero_o = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed cases followed by random traffic, all
// checked against a transaction-level reference of the sharing rules.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

    localparam int W   = 32;
    localparam int OPW = 4;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpSll  = 4'd5;
    localparam logic [3:0] OpSrl  = 4'd6;
    localparam logic [3:0] OpSra  = 4'd7;
    localparam logic [3:0] OpSlt  = 4'd8;
    localparam logic [3:0] OpSltu = 4'd9;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic           v[2];
    logic [W-1:0]   a_in[2];
    logic [W-1:0]   b_in[2];
    logic [OPW-1:0] op_in[2];
    logic           rr[2];

    logic           req0_ready, req1_ready;
    logic           rsp0_valid, rsp1_valid;
    logic [W-1:0]   rsp0_y, rsp1_y;
    logic           rsp0_zero, rsp1_zero;
    logic [W-1:0]   alu_a, alu_b, alu_y;
    logic [OPW-1:0] alu_op;
    logic           alu_zero;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU standing in for the external one.
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            OpAdd:   return a + b;
            OpSub:   return a - b;
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            OpSll:   return b << a[4:0];
            OpSrl:   return b >> a[4:0];
            OpSra:   return $signed(b) >>> a[4:0];
            OpSlt:   return {31'b0, $signed(a) < $signed(b)};
            OpSltu:  return {31'b0, a < b};
            default: return a ^ ~b;
        endcase
    endfunction

    assign alu_y    = alu_fn(alu_op, alu_a, alu_b);
    assign alu_zero = (alu_y == '0);

    alu_share_ctrl #(
        .WIDTH(W),
        .OPW  (OPW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid_i(v[0]),
        .req0_ready_o(req0_ready),
        .req0_a_i    (a_in[0]),
        .req0_b_i    (b_in[0]),
        .req0_op_i   (op_in[0]),
        .req1_valid_i(v[1]),
        .req1_ready_o(req1_ready),
        .req1_a_i    (a_in[1]),
        .req1_b_i    (b_in[1]),
        .req1_op_i   (op_in[1]),
        .rsp0_valid_o(rsp0_valid),
        .rsp0_ready_i(rr[0]),
        .rsp0_y_o    (rsp0_y),
        .rsp0_zero_o (rsp0_zero),
        .rsp1_valid_o(rsp1_valid),
        .rsp1_ready_i(rr[1]),
        .rsp1_y_o    (rsp1_y),
        .rsp1_zero_o (rsp1_zero),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_y_i     (alu_y),
        .alu_zero_i  (alu_zero),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: one operation in flight, identified by how many cycles ago it
    // was accepted; results are visible from two cycles after acceptance.
    bit           m_busy;
    int           m_age;
    int           m_owner;
    int           m_last;
    logic [W-1:0] m_alu_a, m_alu_b, m_res;
    logic [3:0]   m_alu_op;
    logic [W-1:0] m_y[2];
    logic         m_z[2];
    int           last_hs;

    task automatic model_reset();
        m_busy   = 1'b0;
        m_age    = 0;
        m_owner  = 0;
        m_last   = 1;
        m_alu_a  = '0;
        m_alu_b  = '0;
        m_alu_op = '0;
        m_res    = '0;
        m_y[0]   = '0;
        m_y[1]   = '0;
        m_z[0]   = 1'b0;
        m_z[1]   = 1'b0;
        last_hs  = -1;
    endtask

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic step();
        int winner;
        #1;
        winner = -1;
        if (!m_busy) begin
            if (v[0] && v[1]) winner = FixedPrio ? 0 : 1 - m_last;
            else if (v[0]) winner = 0;
            else if (v[1]) winner = 1;
        end
        check("req0_ready", 32'(req0_ready), 32'(winner == 0));
        check("req1_ready", 32'(req1_ready), 32'(winner == 1));
        check("busy", 32'(busy), 32'(m_busy));
        check("rsp0_valid", 32'(rsp0_valid), 32'(m_busy && m_age >= 2 && m_owner == 0));
        check("rsp1_valid", 32'(rsp1_valid), 32'(m_busy && m_age >= 2 && m_owner == 1));
        check("rsp0_y", rsp0_y, m_y[0]);
        check("rsp1_y", rsp1_y, m_y[1]);
        check("rsp0_zero", 32'(rsp0_zero), 32'(m_z[0]));
        check("rsp1_zero", 32'(rsp1_zero), 32'(m_z[1]));
        check("alu_a", alu_a, m_alu_a);
        check("alu_b", alu_b, m_alu_b);
        check("alu_op", 32'(alu_op), 32'(m_alu_op));
        @(posedge clk);
        if (!m_busy) begin
            if (winner >= 0) begin
                m_busy   = 1'b1;
                m_age    = 1;
                m_owner  = winner;
                m_last   = winner;
                m_alu_a  = a_in[winner];
                m_alu_b  = b_in[winner];
                m_alu_op = op_in[winner];
                m_res    = alu_fn(op_in[winner], a_in[winner], b_in[winner]);
            end
        end else if (m_age == 1) begin
            m_age          = 2;
            m_y[m_owner]   = m_res;
            m_z[m_owner]   = (m_res == '0);
        end else if (rr[m_owner]) begin
            m_busy = 1'b0;
        end
        last_hs = winner;
        @(negedge clk);
    endtask

    // Asynchronous reset with both requesters valid: outputs must clear at once.
    task automatic apply_reset();
        v[0]  = 1'b1;
        v[1]  = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp0_y", rsp0_y, 32'd0);
        check("rst_rsp1_y", rsp1_y, 32'd0);
        check("rst_rsp0_zero", 32'(rsp0_zero), 32'd0);
        check("rst_rsp1_zero", 32'(rsp1_zero), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        v[0]  = 1'b0;
        v[1]  = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] op);
        v[i]     = 1'b1;
        a_in[i]  = a;
        b_in[i]  = b;
        op_in[i] = op;
    endtask

    task automatic new_req(input int i);
        logic [W-1:0] b;
        b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
        set_req(i, W'($urandom), b, 4'($urandom_range(0, 10)));
    endtask

    // Random requesters: hold a request until served (occasionally withdraw it).
    task automatic rand_drive(input bit contention);
        for (int i = 0; i < 2; i++) begin
            if (v[i] && last_hs != i) begin
                if (!contention && $urandom_range(0, 19) == 0) v[i] = 1'b0;
            end else if (contention || $urandom_range(0, 2) == 0) begin
                new_req(i);
            end else begin
                v[i] = 1'b0;
            end
            rr[i] = contention || ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            v[i]     = 1'b0;
            a_in[i]  = '0;
            b_in[i]  = '0;
            op_in[i] = '0;
            rr[i]    = 1'b1;
        end
        model_reset();
        #2;
        apply_reset();

        // Single SLL from requester 0.
        set_req(0, 32'd1, 32'h0000_0001, OpSll);
        step();
        v[0] = 1'b0;
        step();
        check("sll_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("sll_y", rsp0_y, 32'h0000_0002);
        check("sll_zero", 32'(rsp0_zero), 32'd0);
        check("sll_rsp1_valid", 32'(rsp1_valid), 32'd0);
        step();
        step();

        // Simultaneous requests straight after reset: requester 0 first.
        apply_reset();
        set_req(0, 32'd1, 32'h0000_0002, OpSrl);
        set_req(1, 32'd1, 32'h8000_0000, OpSra);
        step();
        v[0] = 1'b0;
        step();
        check("sim_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("sim_rsp0_y", rsp0_y, 32'h0000_0001);
        step();
        step();
        v[1] = 1'b0;
        step();
        check("sim_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("sim_rsp1_y", rsp1_y, 32'hC000_0000);
        step();

        // Zero flag.
        set_req(0, 32'd4, 32'd0, OpSll);
        step();
        v[0] = 1'b0;
        step();
        check("zero_y", rsp0_y, 32'd0);
        check("zero_flag", 32'(rsp0_zero), 32'd1);
        step();
        step();

        // Sustained contention: 8 operations back to back.
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            rand_drive(1'b1);
            step();
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Backpressure on response 1 while requester 0 waits.
        rr[0] = 1'b1;
        rr[1] = 1'b0;
        set_req(1, 32'd3, 32'h0000_00F0, OpSrl);
        step();
        v[1] = 1'b0;
        set_req(0, 32'd7, 32'd9, OpAdd);
        for (int k = 0; k < 6; k++) step();
        rr[1] = 1'b1;
        step();
        step();
        v[0] = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Reset during EXEC drops the operation and restores the tie pointer.
        apply_reset();
        set_req(0, W'($urandom), W'($urandom), OpXor);
        set_req(1, W'($urandom), W'($urandom), OpAdd);
        step();
        apply_reset();
        set_req(0, W'($urandom), W'($urandom), OpSub);
        set_req(1, W'($urandom), W'($urandom), OpOr);
        step();
        v[0] = 1'b0;
        for (int k = 0; k < 6; k++) step();
        v[1] = 1'b0;

        // Random traffic with random backpressure.
        for (int k = 0; k < 1500; k++) begin
            rand_drive(1'b0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
